// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and the cyclic first-one search used by the
// four-client round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } arb_pick_t;

    // Walk start, start+1, ... mod NUM_REQ. The loop runs backwards so the
    // candidate closest to start is assigned last and therefore wins.
    function automatic arb_pick_t rr_find(input logic [NUM_REQ-1:0] req,
                                          input logic [IDX_W-1:0]   start,
                                          input logic [NUM_REQ-1:0] excl);
        arb_pick_t        res;
        logic [IDX_W-1:0] c;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = start + k[IDX_W-1:0];
            if (req[c] && !excl[c]) begin
                res.found = 1'b1;
                res.idx   = c;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_decoder_2x4.sv
// Active-low 2-to-4 select decoder; all outputs stay high when not valid.
module sel_decoder_2x4
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               valid,
    output logic [NUM_REQ-1:0] sel_n
);

    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_n[i] = !(valid && (idx == i[IDX_W-1:0]));
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-while-requested grants,
// optional max-hold preemption and an active-low decoded resource select.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en_n,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] sel_n
);

    localparam logic             HOLD_EN   = (MAX_HOLD != 0);
    // With preemption disabled the counter is pinned at zero.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_t         r_state, w_state_d;
    logic [IDX_W-1:0]   r_ptr, w_ptr_d;
    logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_d;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_d;
    logic               r_gnt_valid;

    arb_pick_t          w_rr_pick;
    arb_pick_t          w_pre_pick;
    logic               w_take;
    logic [IDX_W-1:0]   w_take_idx;
    logic [NUM_REQ-1:0] w_own_mask;

    always_comb begin
        w_own_mask   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << r_gnt_idx;
        w_rr_pick    = rr_find(req, r_ptr, '0);
        w_pre_pick   = rr_find(req, r_gnt_idx + IDX_W'(1), w_own_mask);

        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_hold_cnt_d = r_hold_cnt;
        w_gnt_idx_d  = r_gnt_idx;
        w_take       = 1'b0;
        w_take_idx   = r_gnt_idx;

        unique case (r_state)
            ST_IDLE: begin
                if (!en_n && w_rr_pick.found) begin
                    w_take     = 1'b1;
                    w_take_idx = w_rr_pick.idx;
                end
            end
            ST_GRANT: begin
                if (en_n) begin
                    w_state_d = ST_IDLE;
                end else if (!req[r_gnt_idx]) begin
                    if (w_rr_pick.found) begin
                        w_take     = 1'b1;
                        w_take_idx = w_rr_pick.idx;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else if (HOLD_EN && (r_hold_cnt == HOLD_LAST) && w_pre_pick.found) begin
                    w_take     = 1'b1;
                    w_take_idx = w_pre_pick.idx;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_take) begin
            w_state_d    = ST_GRANT;
            w_gnt_idx_d  = w_take_idx;
            w_ptr_d      = w_take_idx + IDX_W'(1);
            w_hold_cnt_d = '0;
        end

        w_gnt_d = (w_state_d == ST_GRANT) ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << w_gnt_idx_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_hold_cnt  <= w_hold_cnt_d;
            r_gnt       <= w_gnt_d;
            r_gnt_idx   <= w_gnt_idx_d;
            r_gnt_valid <= (w_state_d == ST_GRANT);
        end
    end

    sel_decoder_2x4 u_sel_dec (
        .idx   (r_gnt_idx),
        .valid (r_gnt_valid),
        .sel_n (sel_n)
    );

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: one instance with MAX_HOLD=8 and one with
// preemption disabled, both driven by the same stimulus.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       en_n;

    logic [3:0] gnt8, sel8, gnt0, sel0;
    logic [1:0] idx8, idx0;
    logic       vld8, vld0;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state, [0] for MAX_HOLD=8, [1] for MAX_HOLD=0.
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];
    int m_cnt[2];

    logic [10:0] q8[$];
    logic [10:0] q0[$];

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en_n      (en_n),
        .gnt       (gnt8),
        .gnt_idx   (idx8),
        .gnt_valid (vld8),
        .sel_n     (sel8)
    );

    rr_arbiter_4 #(.MAX_HOLD(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en_n      (en_n),
        .gnt       (gnt0),
        .gnt_idx   (idx0),
        .gnt_valid (vld0),
        .sel_n     (sel0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start, input int skip);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            m_idx[i]   = 0;
            m_ptr[i]   = 0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_grant(input int i, input int j);
        m_valid[i] = 1;
        m_idx[i]   = j;
        m_ptr[i]   = (j + 1) % 4;
        m_cnt[i]   = 0;
    endtask

    task automatic model_step(input int i, input int max_hold);
        int j;
        if (m_valid[i] == 0) begin
            j = en_n ? -1 : first_from(req, m_ptr[i], -1);
            if (j >= 0) model_grant(i, j);
        end else if (en_n) begin
            m_valid[i] = 0;
        end else if (!req[m_idx[i]]) begin
            j = first_from(req, m_ptr[i], -1);
            if (j >= 0) model_grant(i, j);
            else m_valid[i] = 0;
        end else begin
            j = first_from(req, m_idx[i] + 1, m_idx[i]);
            if (max_hold != 0 && m_cnt[i] == max_hold - 1 && j >= 0) model_grant(i, j);
            else if (max_hold != 0 && m_cnt[i] < max_hold - 1) m_cnt[i]++;
        end
    endtask

    function automatic logic [10:0] model_out(input int i);
        logic [3:0] g;
        g = (m_valid[i] != 0) ? (4'b0001 << m_idx[i]) : 4'b0000;
        return {g, 2'(m_idx[i]), (m_valid[i] != 0), ~g};
    endfunction

    // Advance one clock: predict, queue, then compare after the edge.
    task automatic step_cycle();
        logic [10:0] e;
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 8);
            model_step(1, 0);
        end
        q8.push_back(model_out(0));
        q0.push_back(model_out(1));
        @(posedge clk);
        #1;
        e = q8.pop_front();
        check_eq("sb_hold8", {gnt8, idx8, vld8, sel8}, e);
        e = q0.pop_front();
        check_eq("sb_hold0", {gnt0, idx0, vld0, sel0}, e);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        en_n = 1'b0;
        model_reset();
        #1;
        check_eq("reset_gnt", gnt8, 4'b0000);
        check_eq("reset_sel", sel8, 4'b1111);
        check_eq("reset_vld", vld8, 1'b0);
        check_eq("reset_idx", idx8, 2'b00);
        step_cycle();
        rst = 1'b0;

        // Reset asserted mid-grant
        req = 4'b1111;
        repeat (3) step_cycle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_gnt8", gnt8, 4'b0000);
        check_eq("async_sel8", sel8, 4'b1111);
        check_eq("async_vld8", vld8, 1'b0);
        check_eq("async_sel0", sel0, 4'b1111);
        step_cycle();
        rst = 1'b0;
        step_cycle();
        check_eq("post_reset_first", gnt8, 4'b0001);
        req = 4'b0000;
        step_cycle();

        // Single 3-cycle pulse on client 2, then ptr=3 picks client 3
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step_cycle();
            check_eq("pulse_sel", sel8, 4'b1011);
            check_eq("pulse_idx", idx8, 2'd2);
        end
        req = 4'b0000;
        step_cycle();
        check_eq("pulse_idle_sel", sel8, 4'b1111);
        req = 4'b1001;
        step_cycle();
        check_eq("ptr3_pick", idx8, 2'd3);
        req = 4'b0000;
        step_cycle();

        // Rotation under constant full request
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            step_cycle();
            check_eq("rot_idx", idx8, (c / 8) % 4);
            check_eq("rot_vld", vld8, 1'b1);
        end
        req = 4'b0000;
        step_cycle();

        // Release handoff from client 0 to client 2
        req = 4'b1000;
        step_cycle();
        req = 4'b0101;
        step_cycle();
        check_eq("handoff_pre", gnt8, 4'b0001);
        step_cycle();
        req = 4'b0100;
        step_cycle();
        check_eq("handoff_gnt", gnt8, 4'b0100);
        req = 4'b0000;
        step_cycle();

        // Enable gating during a grant to client 1
        req = 4'b0010;
        repeat (2) step_cycle();
        check_eq("en_pre_gnt", gnt8, 4'b0010);
        en_n = 1'b1;
        step_cycle();
        check_eq("en_block_gnt", gnt8, 4'b0000);
        en_n = 1'b0;
        req  = 4'b1010;
        step_cycle();
        check_eq("en_resume8", idx8, 2'd3);
        check_eq("en_resume0", idx0, 2'd3);
        req = 4'b0000;
        step_cycle();

        // Preemption disabled: client 2 keeps the grant against client 0
        req = 4'b0100;
        step_cycle();
        req = 4'b0101;
        for (int c = 0; c < 100; c++) begin
            step_cycle();
            check_eq("nohold_gnt", gnt0, 4'b0100);
        end
        req = 4'b0001;
        step_cycle();
        check_eq("nohold_release", gnt0, 4'b0001);
        req = 4'b0000;
        repeat (2) step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource, e.g. a bus or memory port, between four clients. It sequences grants with hold-while-requested semantics and an optional maximum-hold preemption. It drives the resource's select lines through an active-low 2-to-4 decode of the granted index, with the same active-low select convention the team's decoders use.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold a grant while any other requester is waiting. 0 disables preemption. Legal range 0–255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request vector; `req[i]` high means client i wants the resource.
- `en_n`  in  1  active-low arbiter enable; high blocks all grants.
- `gnt`  out  4  registered one-hot grant; all zero when idle.
- `gnt_idx`  out  2  registered index of the granted client; holds its last value when idle.
- `gnt_valid`  out  1  registered; high while any grant is active.
- `sel_n`  out  4  active-low resource select. `sel_n[i] = !(gnt_valid && gnt_idx == i)`. Combinational from registers only.

## Operation
- State machine with two states:
  - IDLE: no grant active.
  - GRANT: client `gnt_idx` owns the resource.
- Round-robin pointer `ptr` (2 bits) names the highest-priority client. On every new grant to client k, `ptr` becomes k+1 mod 4.
- Search order: cyclic from the start index, i.e. start, start+1, … mod 4. The first requester found wins.
- IDLE: if `en_n==0` and `req!=0`, grant the first requester at or after `ptr` and go to GRANT. Otherwise stay in IDLE.
- GRANT, at each edge, with `idx = gnt_idx`:
  - If `en_n==1`: go to IDLE, clear `gnt` and `gnt_valid`, leave `ptr` unchanged.
  - Else if `req[idx]==0` (release): re-arbitrate from `ptr` in the same edge.
    - A requester found: grant it directly, with no idle bubble.
    - No requester found: go to IDLE.
  - Else if `MAX_HOLD!=0`, `hold_cnt==MAX_HOLD-1`, and some `req[j]` with j≠idx is high (preemption): grant the first such j searching from idx+1. The preempted client competes normally afterwards.
  - Else: hold the grant and increment `hold_cnt`.
- `hold_cnt` is cleared on every new grant. It saturates at MAX_HOLD-1 when no other client is waiting, so the grant continues indefinitely.
- A requester never sees two grants in a row through re-arbitration unless it is the only requester.
- Reset values:
  - State IDLE, `ptr=0`, `hold_cnt=0`.
  - `gnt=0000`, `gnt_idx=00`, `gnt_valid=0`, `sel_n=1111`.
- Reset mid-grant: all outputs take their reset values immediately (asynchronously). The first arbitration after reset release starts from client 0.

## Timing
- Latency from request to grant: `req` sampled high at edge E gives `gnt` at E (registered, visible in the cycle after E).
- Minimum grant: 1 cycle, for a `req` pulse one cycle wide.
- Handoff on release: `req[idx]` low before edge E moves the grant to the next client at E, with zero dead cycles.
- Preemption: with persistent competition, a client holds exactly MAX_HOLD cycles.
- `sel_n` changes in the same cycle as `gnt`. There is no extra latency and no glitch path from `req` to `sel_n`.
- `en_n` takes effect at the next edge. `en_n` low plus `req!=0` at edge E gives a grant at E.

## Structure
- Package `rr_arb_pkg`:
  - `NUM_REQ=4`, `IDX_W=2`.
  - State enum `{ST_IDLE, ST_GRANT}`.
  - A function for the cyclic first-one search, taking the request vector, the start index and an exclude mask, and returning an index plus a found flag.
- Sub-module `sel_decoder_2x4`: purely combinational, with inputs `idx[1:0]` and `valid`. It produces the active-low `sel_n[0:3]`, all outputs high when not valid. It is instantiated once.

## Test plan
1. Reset: assert `rst` while `req=1111` is being granted. Required: `sel_n=1111`, `gnt=0000`, `gnt_valid=0` asynchronously. After release, the first grant goes to client 0.
2. Single pulse: `req=0100` high for 3 cycles. Required: `gnt=0100`, `gnt_idx=2`, `sel_n=1011` for 3 cycles, then IDLE with `sel_n=1111`. A following `req=1001` grants client 3 because `ptr=3`.
3. Rotation, MAX_HOLD=8: `req=1111` held constant. Required: grant order 0,1,2,3,0, each held exactly 8 cycles, with no idle cycle between grants.
4. Release handoff: client 0 is granted and `req=0101`. `req[0]` drops before edge E. Required: `gnt=0100` from E, with no gap.
5. Enable: `en_n=1` during a grant to client 1. Required: next edge `gnt=0000` with `ptr` still at 2. Then `en_n=0` with `req=1010` grants client 3.
6. MAX_HOLD=0: client 2 holds `req` for 100 cycles while `req[0]` is also high. Required: client 2 stays granted for all 100 cycles, and client 0 is granted on the edge where `req[2]` falls.
